// File: rtl/rtc_display_regs_if.sv
// Write/snapshot bus between the RTC read controller and the display bank.
// master: RTC side (drives writes and snapshot requests); slave: register bank.
interface rtc_display_regs_if;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_err;
    logic       snap_req;
    logic       snap_pending;
    logic       snap_done;

    modport master (
        output wr_en, wr_addr, wr_data, snap_req,
        input  wr_err, snap_pending, snap_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, snap_req,
        output wr_err, snap_pending, snap_done
    );
endinterface

// File: rtl/rtc_display_regs.sv
// Frame-synchronised RTC display register bank: BCD shadow writes, vsync-aligned
// publish to digit outputs, frame-locked blink phase and frame-aligned alarm.
// Ports: clk, reset (sync, active-high), vsync, alarm_in, bus (write/snapshot
// slave), nine digit outputs, alarma_signal, parpadeo.
module rtc_display_regs #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      vsync,
    input  logic                      alarm_in,
    rtc_display_regs_if.slave         bus,
    output logic [7:0]                seg_t,
    output logic [7:0]                seg_c,
    output logic [7:0]                min_t,
    output logic [7:0]                min_c,
    output logic [7:0]                hora_t,
    output logic [7:0]                hora_c,
    output logic [7:0]                cambio_dia,
    output logic [7:0]                cambio_mes,
    output logic [7:0]                cambio_year,
    output logic                      alarma_signal,
    output logic                      parpadeo
);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    state_t     state;
    logic       vsync_q;
    logic       frame_edge;
    logic       wr_ok;
    logic [7:0] frame_cnt;
    logic [7:0] shadow [6];

    assign frame_edge = vsync & ~vsync_q;

    assign wr_ok = bus.wr_en
                 && (bus.wr_addr <= 3'd5)
                 && (bus.wr_data[7:4] <= 4'd9)
                 && (bus.wr_data[3:0] <= 4'd9);

    assign bus.snap_pending = (state == ARMED);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            vsync_q       <= 1'b0;
            frame_cnt     <= 8'd0;
            parpadeo      <= 1'b0;
            alarma_signal <= 1'b0;
            bus.wr_err    <= 1'b0;
            bus.snap_done <= 1'b0;
            seg_t         <= 8'h00;
            seg_c         <= 8'h00;
            min_t         <= 8'h00;
            min_c         <= 8'h00;
            hora_t        <= 8'h00;
            hora_c        <= 8'h00;
            cambio_dia    <= 8'h01;
            cambio_mes    <= 8'h01;
            cambio_year   <= 8'h00;
            for (int i = 0; i < 6; i++) begin
                shadow[i] <= 8'h00;
            end
        end else begin
            vsync_q       <= vsync;
            bus.wr_err    <= bus.wr_en & ~wr_ok;
            bus.snap_done <= 1'b0;

            if (wr_ok) begin
                shadow[bus.wr_addr] <= bus.wr_data;
            end

            // Publish reads the shadow before this cycle's write lands,
            // so a same-cycle write shows up only at the next publish.
            unique case (state)
                IDLE: begin
                    if (bus.snap_req) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (frame_edge) begin
                        state         <= IDLE;
                        bus.snap_done <= 1'b1;
                        seg_t         <= {4'h0, shadow[0][7:4]};
                        seg_c         <= {4'h0, shadow[0][3:0]};
                        min_t         <= {4'h0, shadow[1][7:4]};
                        min_c         <= {4'h0, shadow[1][3:0]};
                        hora_t        <= {4'h0, shadow[2][7:4]};
                        hora_c        <= {4'h0, shadow[2][3:0]};
                        cambio_dia    <= shadow[3];
                        cambio_mes    <= shadow[4];
                        cambio_year   <= shadow[5];
                    end
                end
                default: state <= IDLE;
            endcase

            if (frame_edge) begin
                alarma_signal <= alarm_in;
                if (frame_cnt == BLINK_LAST) begin
                    frame_cnt <= 8'd0;
                    parpadeo  <= ~parpadeo;
                end else begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rtc_display_regs.sv
// Directed testbench for rtc_display_regs (BLINK_FRAMES = 3).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_rtc_display_regs;

    logic       clk = 1'b0;
    logic       reset;
    logic       vsync;
    logic       alarm_in;
    logic [7:0] seg_t, seg_c, min_t, min_c, hora_t, hora_c;
    logic [7:0] cambio_dia, cambio_mes, cambio_year;
    logic       alarma_signal, parpadeo;

    int n_chk  = 0;
    int n_pass = 0;

    rtc_display_regs_if bus ();

    rtc_display_regs #(.BLINK_FRAMES(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .vsync         (vsync),
        .alarm_in      (alarm_in),
        .bus           (bus.slave),
        .seg_t         (seg_t),
        .seg_c         (seg_c),
        .min_t         (min_t),
        .min_c         (min_c),
        .hora_t        (hora_t),
        .hora_c        (hora_c),
        .cambio_dia    (cambio_dia),
        .cambio_mes    (cambio_mes),
        .cambio_year   (cambio_year),
        .alarma_signal (alarma_signal),
        .parpadeo      (parpadeo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic snap();
        @(negedge clk);
        bus.snap_req = 1'b1;
        @(negedge clk);
        bus.snap_req = 1'b0;
    endtask

    // vsync high for 2 cycles, low for 2; returns 3 cycles after the edge
    task automatic vpulse();
        @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] blink_exp [7];
        blink_exp = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0};

        reset        = 1'b1;
        vsync        = 1'b0;
        alarm_in     = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = 3'd0;
        bus.wr_data  = 8'h00;
        bus.snap_req = 1'b0;

        // reset with vsync toggling
        do_reset();
        chk("rst_seg_t", seg_t, 8'h00);
        chk("rst_hora_c", hora_c, 8'h00);
        chk("rst_dia", cambio_dia, 8'h01);
        chk("rst_mes", cambio_mes, 8'h01);
        chk("rst_year", cambio_year, 8'h00);
        chk("rst_blink", {7'd0, parpadeo}, 8'd0);
        chk("rst_alarm", {7'd0, alarma_signal}, 8'd0);
        chk("rst_done", {7'd0, bus.snap_done}, 8'd0);
        chk("rst_pend", {7'd0, bus.snap_pending}, 8'd0);
        chk("rst_err", {7'd0, bus.wr_err}, 8'd0);

        // rejected writes: bad nibble, then illegal address
        wr(3'd1, 8'h3A);
        chk("rej1_err", {7'd0, bus.wr_err}, 8'd1);
        step();
        chk("rej1_err_clr", {7'd0, bus.wr_err}, 8'd0);
        wr(3'd6, 8'h10);
        chk("rej2_err", {7'd0, bus.wr_err}, 8'd1);
        snap();
        vpulse();
        chk("rej_min_t", min_t, 8'h00);
        chk("rej_min_c", min_c, 8'h00);
        chk("rej_dia_zero", cambio_dia, 8'h00);

        // write full set and publish
        wr(3'd0, 8'h45);
        chk("ok_err", {7'd0, bus.wr_err}, 8'd0);
        wr(3'd1, 8'h59);
        wr(3'd2, 8'h23);
        wr(3'd3, 8'h31);
        wr(3'd4, 8'h12);
        wr(3'd5, 8'h24);
        snap();
        chk("arm_pend", {7'd0, bus.snap_pending}, 8'd1);
        chk("arm_seg_c", seg_c, 8'h00);
        chk("arm_dia", cambio_dia, 8'h00);
        chk("arm_done", {7'd0, bus.snap_done}, 8'd0);
        step();
        vsync = 1'b1;
        step();
        chk("pub_seg_t", seg_t, 8'h04);
        chk("pub_seg_c", seg_c, 8'h05);
        chk("pub_min_t", min_t, 8'h05);
        chk("pub_min_c", min_c, 8'h09);
        chk("pub_hora_t", hora_t, 8'h02);
        chk("pub_hora_c", hora_c, 8'h03);
        chk("pub_dia", cambio_dia, 8'h31);
        chk("pub_mes", cambio_mes, 8'h12);
        chk("pub_year", cambio_year, 8'h24);
        chk("pub_done", {7'd0, bus.snap_done}, 8'd1);
        chk("pub_pend", {7'd0, bus.snap_pending}, 8'd0);
        step();
        chk("pub_done_clr", {7'd0, bus.snap_done}, 8'd0);
        vsync = 1'b0;
        step();
        step();

        // write in the publish cycle: old value is published
        snap();
        vsync        = 1'b1;
        bus.wr_en    = 1'b1;
        bus.wr_addr  = 3'd0;
        bus.wr_data  = 8'h11;
        step();
        bus.wr_en    = 1'b0;
        chk("wp_seg_c", seg_c, 8'h05);
        chk("wp_seg_t", seg_t, 8'h04);
        chk("wp_done", {7'd0, bus.snap_done}, 8'd1);
        vsync = 1'b0;
        step();
        step();

        // snap_req coincident with a frame edge in IDLE: arm only
        bus.snap_req = 1'b1;
        vsync        = 1'b1;
        step();
        bus.snap_req = 1'b0;
        chk("co_pend", {7'd0, bus.snap_pending}, 8'd1);
        chk("co_done", {7'd0, bus.snap_done}, 8'd0);
        chk("co_seg_c", seg_c, 8'h05);
        vsync = 1'b0;
        step();
        step();
        vpulse();
        chk("wp2_seg_c", seg_c, 8'h01);
        chk("wp2_seg_t", seg_t, 8'h01);
        chk("wp2_pend", {7'd0, bus.snap_pending}, 8'd0);

        // blink over 7 frames
        do_reset();
        for (int i = 0; i < 7; i++) begin
            vpulse();
            chk($sformatf("blink_%0d", i + 1), {7'd0, parpadeo},
                blink_exp[i]);
        end

        // alarm: mid-frame glitch ignored
        alarm_in = 1'b1;
        repeat (5) step();
        alarm_in = 1'b0;
        step();
        chk("alm_glitch", {7'd0, alarma_signal}, 8'd0);
        alarm_in = 1'b1;
        step();
        vsync = 1'b1;
        step();
        chk("alm_set", {7'd0, alarma_signal}, 8'd1);
        step();
        vsync    = 1'b0;
        alarm_in = 1'b0;
        repeat (3) step();
        chk("alm_hold", {7'd0, alarma_signal}, 8'd1);
        vpulse();
        chk("alm_clr", {7'd0, alarma_signal}, 8'd0);

        // reset mid-operation drops a pending snapshot
        snap();
        chk("mid_pend", {7'd0, bus.snap_pending}, 8'd1);
        do_reset();
        chk("mid_pend_rst", {7'd0, bus.snap_pending}, 8'd0);
        chk("mid_dia_rst", cambio_dia, 8'h01);
        vpulse();
        chk("mid_no_pub", cambio_mes, 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
